// File: rtl/mult_pipe_chain_pkg.sv
// Shared constants and packed stage-word layout for mult_pipe_chain.
// Stage word is {pc, instr, we, addr, data}, with data in the LSBs.
package mult_pipe_chain_pkg;

    localparam int MULT_PIPE_MAX_STAGES = 8;
    localparam int OCC_W = $clog2(MULT_PIPE_MAX_STAGES + 1);

    function automatic int addr_lsb(input int dw);
        return dw;
    endfunction

    function automatic int we_bit(input int dw, input int aw);
        return dw + aw;
    endfunction

    function automatic int instr_lsb(input int dw, input int aw);
        return dw + aw + 1;
    endfunction

    function automatic int pc_lsb(input int dw, input int aw);
        return 2 * dw + aw + 1;
    endfunction

    function automatic int payload_w(input int dw, input int aw);
        return 3 * dw + aw + 1;
    endfunction

endpackage

// File: rtl/mult_pipe_chain_stage.sv
// One multiplier pipeline stage: valid bit plus packed payload word.
// Flush beats stall; an asynchronous reset clears both.
module mult_pipe_chain_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_word,
    output logic         valid,
    output logic [W-1:0] word
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            word  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            word  <= '0;
        end else if (!stall) begin
            valid <= in_valid;
            word  <= in_word;
        end
    end

endmodule

// File: rtl/mult_pipe_chain.sv
// STAGES-deep multiplier result chain with stall, flush and occupancy.
// Define MULT_PIPE_HAZARD_EN to add the rs1/rs2 in-flight write probe.
module mult_pipe_chain
    import mult_pipe_chain_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int STAGES = 4
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic              in_we_i,
    input  logic [DATA_W-1:0] in_instr_i,
    input  logic [DATA_W-1:0] in_pc_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_we_o,
    output logic [DATA_W-1:0] out_instr_o,
    output logic [DATA_W-1:0] out_pc_o,
`ifdef MULT_PIPE_HAZARD_EN
    output logic [OCC_W-1:0]  occupancy_o,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic              hazard_o
`else
    output logic [OCC_W-1:0]  occupancy_o
`endif
);

    localparam int PW    = payload_w(DATA_W, ADDR_W);
    localparam int A_LSB = addr_lsb(DATA_W);
    localparam int WE_B  = we_bit(DATA_W, ADDR_W);
    localparam int I_LSB = instr_lsb(DATA_W, ADDR_W);
    localparam int P_LSB = pc_lsb(DATA_W, ADDR_W);

    logic [STAGES-1:0] valid;
    logic [PW-1:0]     word [STAGES];
    logic [PW-1:0]     in_word;
    logic [PW-1:0]     last;
    logic              last_v;
    logic [OCC_W-1:0]  occ;

    assign in_word = {in_pc_i, in_instr_i, in_we_i, in_addr_i, in_data_i};

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_head
                mult_pipe_chain_stage #(.W(PW)) u_stage (
                    .clk      (clk_i),
                    .rst      (rsn_i),
                    .stall    (stall_i),
                    .flush    (flush_i),
                    .in_valid (in_valid_i),
                    .in_word  (in_word),
                    .valid    (valid[k]),
                    .word     (word[k])
                );
            end else begin : g_body
                mult_pipe_chain_stage #(.W(PW)) u_stage (
                    .clk      (clk_i),
                    .rst      (rsn_i),
                    .stall    (stall_i),
                    .flush    (flush_i),
                    .in_valid (valid[k-1]),
                    .in_word  (word[k-1]),
                    .valid    (valid[k]),
                    .word     (word[k])
                );
            end
        end
    endgenerate

    // Bubbles count as zero in the in/out terms, so occ tracks valid bits.
    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            occ <= '0;
        end else if (flush_i) begin
            occ <= '0;
        end else if (!stall_i) begin
            occ <= occ + OCC_W'(in_valid_i) - OCC_W'(valid[STAGES-1]);
        end
    end

    assign occupancy_o = occ;
    assign in_ready_o  = !stall_i && !rsn_i;

    assign last_v      = valid[STAGES-1];
    assign last        = word[STAGES-1];
    assign out_valid_o = last_v;
    assign out_data_o  = last_v ? last[DATA_W-1:0]        : '0;
    assign out_addr_o  = last_v ? last[A_LSB +: ADDR_W]   : '0;
    assign out_we_o    = last_v & last[WE_B];
    assign out_instr_o = last_v ? last[I_LSB +: DATA_W]   : '0;
    assign out_pc_o    = last_v ? last[P_LSB +: DATA_W]   : '0;

`ifdef MULT_PIPE_HAZARD_EN
    logic [ADDR_W-1:0] st_addr;

    always_comb begin
        hazard_o = 1'b0;
        st_addr  = '0;
        for (int i = 0; i < STAGES; i++) begin
            st_addr = word[i][A_LSB +: ADDR_W];
            if (valid[i] && word[i][WE_B]) begin
                if ((rs1_addr_i != '0) && (st_addr == rs1_addr_i))
                    hazard_o = 1'b1;
                if ((rs2_addr_i != '0) && (st_addr == rs2_addr_i))
                    hazard_o = 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mult_pipe_chain.sv
// Self-checking bench for mult_pipe_chain: queue model plus directed
// literal checks, followed by randomized traffic with stall/flush/reset.
`timescale 1ns/100ps
module tb_mult_pipe_chain;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int ST = 4;

    logic          clk_i = 1'b0;
    logic          rsn_i = 1'b1;
    logic          stall_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_we_i = 1'b0;
    logic [DW-1:0] in_data_i = '0;
    logic [DW-1:0] in_instr_i = '0;
    logic [DW-1:0] in_pc_i = '0;
    logic [AW-1:0] in_addr_i = '0;
    logic [AW-1:0] rs1 = '0;
    logic [AW-1:0] rs2 = '0;

    logic          in_ready_o;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic [AW-1:0] out_addr_o;
    logic          out_we_o;
    logic [DW-1:0] out_instr_o;
    logic [DW-1:0] out_pc_o;
    logic [3:0]    occupancy_o;
`ifdef MULT_PIPE_HAZARD_EN
    logic          hazard_o;
`endif

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    mult_pipe_chain #(.DATA_W(DW), .ADDR_W(AW), .STAGES(ST)) dut (
        .clk_i       (clk_i),
        .rsn_i       (rsn_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_addr_i   (in_addr_i),
        .in_we_i     (in_we_i),
        .in_instr_i  (in_instr_i),
        .in_pc_i     (in_pc_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_addr_o  (out_addr_o),
        .out_we_o    (out_we_o),
        .out_instr_o (out_instr_o),
        .out_pc_o    (out_pc_o),
`ifdef MULT_PIPE_HAZARD_EN
        .occupancy_o (occupancy_o),
        .rs1_addr_i  (rs1),
        .rs2_addr_i  (rs2),
        .hazard_o    (hazard_o)
`else
        .occupancy_o (occupancy_o)
`endif
    );

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Model: the pipe is a fixed-length queue of entries, head = stage 0.
    typedef struct packed {
        logic          v;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] instr;
        logic [DW-1:0] pc;
    } ent_t;

    ent_t pipe[$];

    function automatic void m_clear();
        pipe.delete();
        for (int i = 0; i < ST; i++) pipe.push_back('0);
    endfunction

    always @(posedge clk_i or posedge rsn_i) begin : model
        ent_t e;
        if (rsn_i || flush_i) begin
            m_clear();
        end else if (!stall_i) begin
            e.v     = in_valid_i;
            e.data  = in_data_i;
            e.addr  = in_addr_i;
            e.we    = in_we_i;
            e.instr = in_instr_i;
            e.pc    = in_pc_i;
            pipe.push_front(e);
            void'(pipe.pop_back());
        end
    end

    always @(negedge clk_i) begin : compare
        ent_t t;
        int   occ;
        logic hz;
        t   = pipe[ST-1];
        occ = 0;
        hz  = 1'b0;
        foreach (pipe[i]) begin
            if (pipe[i].v) occ++;
            if (pipe[i].v && pipe[i].we &&
                ((rs1 != 0 && pipe[i].addr == rs1) ||
                 (rs2 != 0 && pipe[i].addr == rs2)))
                hz = 1'b1;
        end
        chk("out_valid", DW'(out_valid_o), DW'(t.v));
        chk("out_data", out_data_o, t.v ? t.data : '0);
        chk("out_addr", DW'(out_addr_o), t.v ? DW'(t.addr) : '0);
        chk("out_we", DW'(out_we_o), DW'(t.v & t.we));
        chk("out_instr", out_instr_o, t.v ? t.instr : '0);
        chk("out_pc", out_pc_o, t.v ? t.pc : '0);
        chk("occupancy", DW'(occupancy_o), DW'(occ));
        chk("in_ready", DW'(in_ready_o), DW'(!stall_i && !rsn_i));
`ifdef MULT_PIPE_HAZARD_EN
        chk("hazard", DW'(hazard_o), DW'(hz));
`endif
    end

    task automatic drive(input logic st, input logic fl, input logic v,
                         input logic [DW-1:0] pc, input logic [AW-1:0] addr,
                         input logic we);
        stall_i    = st;
        flush_i    = fl;
        in_valid_i = v;
        in_pc_i    = pc;
        in_addr_i  = addr;
        in_we_i    = we;
        in_data_i  = $urandom;
        in_instr_i = $urandom;
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    int occ_exp[10] = '{1, 2, 3, 4, 4, 4, 3, 2, 1, 0};
    int peak;

    initial begin
        m_clear();
        in_valid_i = 1'b1;
        in_we_i    = 1'b1;
        in_pc_i    = 32'h55;
        repeat (3) begin
            @(posedge clk_i);
            #2;
            chk("rst_valid", DW'(out_valid_o), 0);
            chk("rst_occ", DW'(occupancy_o), 0);
            chk("rst_ready", DW'(in_ready_o), 0);
            chk("rst_pc", out_pc_o, 0);
        end
        in_valid_i = 1'b0;
        rsn_i      = 1'b0;
        idle();

        peak = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, i < 6, 32'h100 + 32'(4 * i), AW'(i + 1), 1'b1);
            if (int'(occupancy_o) > peak) peak = int'(occupancy_o);
            chk("stream_occ", DW'(occupancy_o), DW'(occ_exp[i]));
            if (i >= 3 && i <= 8) begin
                chk("stream_valid", DW'(out_valid_o), 1);
                chk("stream_pc", out_pc_o, 32'h100 + 32'(4 * (i - 3)));
            end else begin
                chk("stream_bubble", DW'(out_valid_o), 0);
            end
        end
        chk("stream_peak", DW'(peak), 4);

        drive(1'b0, 1'b0, 1'b1, 32'h200, 5'd1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 32'h204, 5'd2, 1'b1);
        repeat (3) begin
            drive(1'b1, 1'b0, 1'b1, 32'hDEAD, 5'd3, 1'b1);
            chk("stall_occ", DW'(occupancy_o), 2);
            chk("stall_ready", DW'(in_ready_o), 0);
            chk("stall_valid", DW'(out_valid_o), 0);
        end
        idle();
        chk("rel_occ", DW'(occupancy_o), 2);
        idle();
        chk("rel_pc0", out_pc_o, 32'h200);
        idle();
        chk("rel_pc1", out_pc_o, 32'h204);
        idle();
        chk("rel_empty", DW'(out_valid_o), 0);
        chk("rel_occ0", DW'(occupancy_o), 0);

        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b0, 1'b1, 32'h300 + 32'(4 * i), 5'd4, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 32'h3FF, 5'd4, 1'b1);
        chk("flush_occ", DW'(occupancy_o), 0);
        repeat (4) begin
            idle();
            chk("flush_valid", DW'(out_valid_o), 0);
        end

`ifdef MULT_PIPE_HAZARD_EN
        rs1 = 5'd5;
        rs2 = 5'd0;
        drive(1'b0, 1'b0, 1'b1, 32'h500, 5'd5, 1'b1);
        chk("haz_s0", DW'(hazard_o), 1);
        repeat (3) begin
            idle();
            chk("haz_fly", DW'(hazard_o), 1);
        end
        idle();
        chk("haz_gone", DW'(hazard_o), 0);
        rs1 = 5'd0;
        drive(1'b0, 1'b0, 1'b1, 32'h504, 5'd0, 1'b1);
        chk("haz_x0", DW'(hazard_o), 0);
        rs1 = 5'd5;
        drive(1'b0, 1'b0, 1'b1, 32'h508, 5'd5, 1'b0);
        chk("haz_nowe", DW'(hazard_o), 0);
        repeat (4) idle();
        rs1 = '0;
`endif

        for (int i = 0; i < 4; i++)
            drive(1'b0, 1'b0, 1'b1, 32'h400 + 32'(4 * i), 5'd6, 1'b1);
        chk("ar_full", DW'(occupancy_o), 4);
        chk("ar_pc", out_pc_o, 32'h400);
        #0.5 rsn_i = 1'b1;
        #0.5;
        chk("ar_valid", DW'(out_valid_o), 0);
        chk("ar_occ", DW'(occupancy_o), 0);
        chk("ar_pc0", out_pc_o, 0);
        chk("ar_data0", out_data_o, 0);
        #0.5 rsn_i = 1'b0;
        idle();
        chk("ar_after", DW'(out_valid_o), 0);
        chk("ar_after_occ", DW'(occupancy_o), 0);

        for (int i = 0; i < 400; i++) begin
            rs1 = AW'($urandom_range(0, 7));
            rs2 = AW'($urandom_range(0, 7));
            drive($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < 60, $urandom,
                  AW'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 99) == 0) begin
                #0.5 rsn_i = 1'b1;
                #0.5 rsn_i = 1'b0;
            end
        end
        idle();
        @(posedge clk_i);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
